lu_sweep_seq: RTL and testbench
===============================

LU_SWEEP_SEQ -- requirements
Module: lu_sweep_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand and result bit width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to sweep the latched operands through all four logic operations.
REQ-005 a  input  WIDTH  operand A; sampled only on an accepted start.
REQ-006 b  input  WIDTH  operand B; sampled only on an accepted start.
REQ-007 ready  output  1  high only in IDLE; start accepted when start && ready on a rising edge.
REQ-008 busy  output  1  high in RUN.
REQ-009 valid  output  1  results available; high in DONE.
REQ-010 ack  input  1  consumer acknowledge; meaningful only while valid.
REQ-011 res_nand, res_and, res_nor, res_or  output  WIDTH each  captured results of the four operations.
REQ-012 op_sel  output  2  current {sel_grupo, sel_porta} driven to the logic core: 00 NAND, 01 AND, 10 NOR, 11 OR.

Function
REQ-013 States: IDLE, RUN, DONE; a 2-bit op counter cnt sequences RUN.
REQ-014 IDLE -> RUN on accepted start; a, b latched into internal registers; cnt cleared to 0.
REQ-015 In RUN, op_sel = cnt; the core result for op_sel is written into the matching res_* register on each edge; cnt increments.
REQ-016 RUN -> DONE on the edge that captures cnt = 3; this is the 4th edge after acceptance, so valid is first visible 4 cycles after the accept edge.
REQ-017 DONE: valid held high and res_* held stable until ack is sampled high; then DONE -> IDLE and valid deasserts on that edge.
REQ-018 start while not IDLE is ignored and not queued; a/b changes outside acceptance have no effect.
REQ-019 ack outside DONE is ignored; ack and start high together in DONE: only ack acts, start is not accepted until the next IDLE cycle.
REQ-020 Results are bitwise: NAND = ~(a&b), AND = a&b, NOR = ~(a|b), OR = a|b on latched operands; no carry or width growth.
REQ-021 res_* registers retain the last completed sweep in IDLE; a new sweep overwrites them progressively during RUN.
REQ-022 op_sel = 00 outside RUN.

Reset
REQ-023 rst_n low forces immediately, regardless of clk: state IDLE, cnt 0, ready 1, busy 0, valid 0, op_sel 00, all res_* 0, latched operands 0.
REQ-024 Reset during RUN or DONE aborts the sweep; no partial results remain visible.
REQ-025 Operation resumes on the first rising edge after rst_n deasserts; start may be accepted on that edge.

Structure
REQ-026 Shared package holds the state enumeration (IDLE, RUN, DONE) and the op_sel encoding constants (OP_NAND=00, OP_AND=01, OP_NOR=10, OP_OR=11).
REQ-027 A single combinational sub-module lu_core (WIDTH-bit; inputs a, b, op_sel; output y) performs the selected operation; lu_sweep_seq instantiates it once.
REQ-028 Control FSM, counter and result registers reside in lu_sweep_seq; the total RTL is 120-400 lines.

Verification
REQ-029 Basic sweep, WIDTH=4: a=1100, b=1010, start pulse -> after 4 cycles valid=1, res_nand=0111, res_and=1000, res_nor=0001, res_or=1110.
REQ-030 Op sequencing: same stimulus -> op_sel reads 00,01,10,11 on successive RUN cycles; busy=1 for exactly 4 cycles.
REQ-031 Start while busy: second start with a=1111, b=0000 in the 2nd RUN cycle -> ignored; results match REQ-029.
REQ-032 Ack hold: withhold ack 10 cycles -> valid and res_* stable; ack pulse -> valid=0, ready=1 next cycle; start+ack together in DONE -> no new sweep.
REQ-033 Async reset mid-RUN: drop rst_n between edges in the 3rd RUN cycle -> immediately ready=1, busy=0, valid=0, res_*=0000.
REQ-034 Exhaustive: all 256 (a,b) pairs at WIDTH=4 -> each res_* matches the bitwise reference.

Source files
------------

// File: rtl/lu_sweep_seq_pkg.sv
// Shared constants for the logic-unit sweep sequencer: FSM state codes and
// the op_sel encoding presented to the combinational logic core.
package lu_sweep_seq_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] op_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // op_sel = {sel_grupo, sel_porta}
    localparam op_t OP_NAND = 2'b00;
    localparam op_t OP_AND  = 2'b01;
    localparam op_t OP_NOR  = 2'b10;
    localparam op_t OP_OR   = 2'b11;

endpackage

// File: rtl/lu_sweep_seq_if.sv
// Handshake, operand and result bundle of the sweep sequencer; the consumer
// side uses the master modport, the sequencer the slave modport.
interface lu_sweep_seq_if #(
    parameter int unsigned WIDTH = 4
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             valid;
    logic             ack;
    logic [WIDTH-1:0] res_nand;
    logic [WIDTH-1:0] res_and;
    logic [WIDTH-1:0] res_nor;
    logic [WIDTH-1:0] res_or;
    logic [1:0]       op_sel;

    modport master (
        output start, a, b, ack,
        input  ready, busy, valid, res_nand, res_and, res_nor, res_or, op_sel
    );

    modport slave (
        input  start, a, b, ack,
        output ready, busy, valid, res_nand, res_and, res_nor, res_or, op_sel
    );

endinterface

// File: rtl/lu_sweep_seq_core.sv
// Combinational logic core: applies the bitwise operation selected by op_sel
// to a and b.
import lu_sweep_seq_pkg::*;

module lu_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op_sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op_sel)
            OP_NAND: y = ~(a & b);
            OP_AND:  y = a & b;
            OP_NOR:  y = ~(a | b);
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/lu_sweep_seq.sv
// Sweep sequencer: latches a/b on an accepted start, steps the logic core
// through all four operations and holds the captured results until ack.
import lu_sweep_seq_pkg::*;

module lu_sweep_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    lu_sweep_seq_if.slave bus
);

    state_t           state;
    logic [1:0]       cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] core_y;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] res_nand;
    logic [WIDTH-1:0] res_and;
    logic [WIDTH-1:0] res_nor;
    logic [WIDTH-1:0] res_or;

    assign op_sel = (state == RUN) ? cnt : OP_NAND;

    lu_core #(.WIDTH(WIDTH)) u_core (
        .a      (a_q),
        .b      (b_q),
        .op_sel (op_sel),
        .y      (core_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_nand <= '0;
            res_and  <= '0;
            res_nor  <= '0;
            res_or   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // cnt doubles as op_sel, so it also picks the result slot
                    case (cnt)
                        OP_NAND: res_nand <= core_y;
                        OP_AND:  res_and  <= core_y;
                        OP_NOR:  res_nor  <= core_y;
                        default: res_or   <= core_y;
                    endcase
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.busy     = (state == RUN);
    assign bus.valid    = (state == DONE);
    assign bus.op_sel   = op_sel;
    assign bus.res_nand = res_nand;
    assign bus.res_and  = res_and;
    assign bus.res_nor  = res_nor;
    assign bus.res_or   = res_or;

endmodule

// File: tb/tb_lu_sweep_seq.sv
// Bench for lu_sweep_seq: per-scenario tasks with a scoreboard of expected
// result sets pushed at start and popped when valid rises.
module tb_lu_sweep_seq;

    localparam int unsigned W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lu_sweep_seq_if #(.WIDTH(W)) bus ();

    lu_sweep_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [4*W-1:0] sb_q[$];

    function automatic logic [4*W-1:0] ref_pack(input logic [W-1:0] x, input logic [W-1:0] y);
        return {~(x & y), x & y, ~(x | y), x | y};
    endfunction

    function automatic logic [4*W-1:0] obs();
        return {bus.res_nand, bus.res_and, bus.res_nor, bus.res_or};
    endfunction

    // Called on a negedge with ready high; returns on the negedge after the accept edge.
    task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        sb_q.push_back(ref_pack(x, y));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.ack = 1'b0; bus.a = '0; bus.b = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.ready, bus.busy, bus.valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_flags: got rdy/busy/vld=%b expected 100", {bus.ready, bus.busy, bus.valid});
        end
        tests_run++;
        if (bus.op_sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_op_sel: got %b expected 00", bus.op_sel);
        end
        tests_run++;
        if (obs() !== '0) begin
            tests_failed++;
            $display("FAIL reset_results: got %h expected 0000", obs());
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_sweep();
        logic [4*W-1:0] exp;
        drive_start(4'b1100, 4'b1010);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (bus.busy !== 1'b1 || bus.op_sel !== 2'(i)) begin
                tests_failed++;
                $display("FAIL seq_cycle%0d: got busy=%b op_sel=%b expected busy=1 op_sel=%b",
                         i, bus.busy, bus.op_sel, 2'(i));
            end
            @(negedge clk);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_done: got busy=%b valid=%b expected busy=0 valid=1", bus.busy, bus.valid);
        end
        exp = sb_q.pop_front();
        tests_run++;
        if (obs() !== exp || obs() !== 16'b0111_1000_0001_1110) begin
            tests_failed++;
            $display("FAIL basic_results: got %b expected %b", obs(), 16'b0111_1000_0001_1110);
        end
        pulse_ack();
        tests_run++;
        if (bus.valid !== 1'b0 || bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ack: got valid=%b ready=%b expected valid=0 ready=1", bus.valid, bus.ready);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        logic [4*W-1:0] exp;
        drive_start(4'b1100, 4'b1010);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'b1111; bus.b = 4'b0000;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(n);
        tests_run++;
        if (n !== 2) begin
            tests_failed++;
            $display("FAIL busy_start_latency: got %0d expected 2", n);
        end
        exp = sb_q.pop_front();
        tests_run++;
        if (obs() !== exp) begin
            tests_failed++;
            $display("FAIL busy_start_results: got %b expected %b", obs(), exp);
        end
        pulse_ack();
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start_not_queued: got busy=%b ready=%b expected busy=0 ready=1", bus.busy, bus.ready);
        end
    endtask

    task automatic test_ack_hold();
        int n;
        logic [4*W-1:0] exp;
        drive_start(4'b0110, 4'b0011);
        wait_valid(n);
        tests_run++;
        if (n !== 4) begin
            tests_failed++;
            $display("FAIL hold_latency: got %0d expected 4", n);
        end
        exp = sb_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (bus.valid !== 1'b1 || obs() !== exp) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: got valid=%b res=%b expected valid=1 res=%b", i, bus.valid, obs(), exp);
            end
            @(negedge clk);
        end
        pulse_ack();
        tests_run++;
        if (bus.valid !== 1'b0 || bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_ack: got valid=%b ready=%b expected valid=0 ready=1", bus.valid, bus.ready);
        end
        // second sweep, then start and ack together while in DONE
        drive_start(4'b1001, 4'b0101);
        wait_valid(n);
        exp = sb_q.pop_front();
        bus.start = 1'b1; bus.ack = 1'b1; bus.a = 4'b1111; bus.b = 4'b1111;
        @(negedge clk);
        bus.start = 1'b0; bus.ack = 1'b0;
        tests_run++;
        if ({bus.ready, bus.busy, bus.valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL start_ack_together: got rdy/busy/vld=%b expected 100", {bus.ready, bus.busy, bus.valid});
        end
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || obs() !== exp) begin
            tests_failed++;
            $display("FAIL start_ack_no_sweep: got busy=%b res=%b expected busy=0 res=%b", bus.busy, obs(), exp);
        end
    endtask

    task automatic test_async_reset();
        int n;
        logic [4*W-1:0] exp;
        drive_start(4'b1100, 4'b1010);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        tests_run++;
        if ({bus.ready, bus.busy, bus.valid} !== 3'b100 || bus.op_sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset_flags: got rdy/busy/vld=%b op_sel=%b expected 100 00",
                     {bus.ready, bus.busy, bus.valid}, bus.op_sel);
        end
        tests_run++;
        if (obs() !== '0) begin
            tests_failed++;
            $display("FAIL async_reset_results: got %b expected 0", obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(4'b0101, 4'b0110);
        wait_valid(n);
        tests_run++;
        if (n !== 4) begin
            tests_failed++;
            $display("FAIL post_reset_latency: got %0d expected 4", n);
        end
        exp = sb_q.pop_front();
        tests_run++;
        if (obs() !== exp) begin
            tests_failed++;
            $display("FAIL post_reset_results: got %b expected %b", obs(), exp);
        end
        pulse_ack();
    endtask

    task automatic test_exhaustive();
        int n;
        logic [4*W-1:0] exp;
        logic [7:0] ab;
        for (int i = 0; i < 256; i++) begin
            ab = 8'(i);
            drive_start(ab[7:4], ab[3:0]);
            wait_valid(n);
            tests_run++;
            if (n !== 4) begin
                tests_failed++;
                $display("FAIL exh_latency a=%b b=%b: got %0d expected 4", ab[7:4], ab[3:0], n);
            end
            exp = sb_q.pop_front();
            tests_run++;
            if (obs() !== exp) begin
                tests_failed++;
                $display("FAIL exh_results a=%b b=%b: got %b expected %b", ab[7:4], ab[3:0], obs(), exp);
            end
            pulse_ack();
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_start_while_busy();
        test_ack_hold();
        test_async_reset();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
